// File: rtl/gf22_pad_bank_seq.sv
// gf22_pad_bank_seq: power sequencing, retention and staggered OE grants for one GF22 pad bank
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   en_i, ret_i        bank power request, retention request
//   drv_i, slw_i       drive strength and slew applied to every pad while ACTIVE
//   oe_req_i           requested output enables
//   pad_oe_o           granted output enables
//   pad_attributes_o   per-pad {SLW, DRV[1:0], RETC, BIAS, IOPWROK, PWROK}, zero-extended to PADATTR
//   ready_o, busy_o    bank ACTIVE, OE grant pending
module gf22_pad_bank_seq #(
  parameter int unsigned NPADS          = 8,
  parameter int unsigned PADATTR        = 16,
  parameter int unsigned SIDE           = 0,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned STAGGER_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     ret_i,
  input  logic [1:0]               drv_i,
  input  logic                     slw_i,
  input  logic [NPADS-1:0]         oe_req_i,
  output logic [NPADS-1:0]         pad_oe_o,
  output logic [NPADS*PADATTR-1:0] pad_attributes_o,
  output logic                     ready_o,
  output logic                     busy_o
);
  typedef enum logic [2:0] {S_OFF, S_BIAS, S_PWR, S_IO, S_ACT, S_RET, S_DOWN} state_e;
  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] STAG   = 8'(STAGGER_CYCLES - 1);
  state_e state_q, state_d;
  logic [7:0] settle_q, settle_d, stag_q, stag_d;
  logic [NPADS-1:0] pad_oe_q, pad_oe_d, avail, grant;
  logic [6:0] attr_q, attr_d;
  logic ready_q, ready_d, busy_q, busy_d, stag_ok;
  logic unused_side;
  assign unused_side = (SIDE != 0);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_OFF;
      settle_q <= '0;
      stag_q   <= '0;
      pad_oe_q <= '0;
      attr_q   <= 7'b0001000;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      stag_q   <= stag_d;
      pad_oe_q <= pad_oe_d;
      attr_q   <= attr_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    settle_d = (settle_q != '0) ? settle_q - 8'd1 : '0;
    case (state_q)
      S_OFF:  if (en_i) begin state_d = S_BIAS; settle_d = SETTLE; end
      S_BIAS: if (!en_i) begin state_d = S_DOWN; settle_d = SETTLE; end
              else if (settle_q == '0) begin state_d = S_PWR; settle_d = SETTLE; end
      S_PWR:  if (!en_i) begin state_d = S_DOWN; settle_d = SETTLE; end
              else if (settle_q == '0) begin state_d = S_IO; settle_d = SETTLE; end
      S_IO:   if (!en_i) begin state_d = S_DOWN; settle_d = SETTLE; end
              else if (settle_q == '0) state_d = S_ACT;
      S_ACT:  if (ret_i) state_d = S_RET;
              else if (!en_i) begin state_d = S_DOWN; settle_d = SETTLE; end
      S_RET:  if (!ret_i) state_d = S_ACT;
      S_DOWN: if (settle_q == '0) state_d = S_OFF;
      default: state_d = S_OFF;
    endcase
  end
  // lowest pending pad as a one-hot via x & -x
  assign avail   = oe_req_i & ~pad_oe_q;
  assign grant   = avail & (~avail + NPADS'(1));
  assign stag_ok = (state_q == S_ACT) && (state_d != S_DOWN);
  always_comb begin
    pad_oe_d = !(state_d inside {S_ACT, S_RET}) ? '0 :
               stag_ok ? ((pad_oe_q & oe_req_i) | ((stag_q == '0) ? grant : '0)) : pad_oe_q;
    stag_d = (stag_ok && stag_q == '0 && |avail) ? STAG :
             (stag_q != '0) ? stag_q - 8'd1 : '0;
    // PWROK/BIAS keep whatever level they reached while DOWN settles
    attr_d[0]   = (state_d inside {S_PWR, S_IO, S_ACT, S_RET}) || (state_d == S_DOWN && attr_q[0]);
    attr_d[1]   = state_d inside {S_IO, S_ACT, S_RET};
    attr_d[2]   = (state_d != S_OFF) && (state_d != S_DOWN || attr_q[2]);
    attr_d[3]   = state_d != S_RET;
    attr_d[6:4] = (state_q == S_ACT) ? {slw_i, drv_i} : attr_q[6:4];
    ready_d     = state_d == S_ACT;
    busy_d      = ready_d && |(oe_req_i & ~pad_oe_d);
  end
  assign pad_oe_o         = pad_oe_q;
  assign pad_attributes_o = {NPADS{PADATTR'(attr_q)}};
  assign ready_o          = ready_q;
  assign busy_o           = busy_q;
endmodule

// File: tb/tb_gf22_pad_bank_seq.sv
// tb_gf22_pad_bank_seq: directed and random checks of the pad bank sequencer against a behavioural model
module tb_gf22_pad_bank_seq;
  localparam int NP = 8, PA = 16, S = 16, STAG = 2;
  localparam int P_OFF = 0, P_BIAS = 1, P_PWR = 2, P_IO = 3, P_ACT = 4, P_RET = 5, P_DOWN = 6;
  logic clk = 0, rst_n = 0, en = 0, ret = 0, slw = 0, ready, busy;
  logic [1:0] drv = 0;
  logic [NP-1:0] oe_req = 0, pad_oe;
  logic [NP*PA-1:0] attr_bus;
  int total = 0, bad = 0;
  int m_ph = P_OFF, m_left = 0, m_cyc = 0, m_last = -100000;
  logic [NP-1:0] m_oe = 0;
  logic m_pwr = 0, m_iop = 0, m_bias = 0, m_retc = 1, m_slw = 0, m_rdy = 0, m_busy = 0;
  logic [1:0] m_drv = 0;

  gf22_pad_bank_seq #(.NPADS(NP), .PADATTR(PA), .SIDE(0), .SETTLE_CYCLES(S), .STAGGER_CYCLES(STAG)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .ret_i(ret), .drv_i(drv), .slw_i(slw),
    .oe_req_i(oe_req), .pad_oe_o(pad_oe), .pad_attributes_o(attr_bus), .ready_o(ready), .busy_o(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = P_OFF; m_left = 0; m_last = -100000; m_oe = '0;
    m_pwr = 0; m_iop = 0; m_bias = 0; m_retc = 1; m_drv = 0; m_slw = 0; m_rdy = 0; m_busy = 0;
  endtask

  // one clock edge of the bank: m_left counts the cycles still to spend in a settle step
  task automatic m_edge();
    int nph;
    logic [NP-1:0] noe;
    logic done;
    nph = m_ph; noe = m_oe; done = 0;
    m_cyc++;
    case (m_ph)
      P_OFF: if (en) begin nph = P_BIAS; m_left = S; end
      P_BIAS, P_PWR, P_IO:
        if (!en) begin nph = P_DOWN; m_left = S; end
        else begin m_left--; if (m_left == 0) begin nph = m_ph + 1; m_left = S; end end
      P_ACT: if (ret) nph = P_RET; else if (!en) begin nph = P_DOWN; m_left = S; end
      P_RET: if (!ret) nph = P_ACT;
      P_DOWN: begin m_left--; if (m_left == 0) nph = P_OFF; end
      default: nph = P_OFF;
    endcase
    if (m_ph == P_ACT) begin
      m_drv = drv; m_slw = slw;
      if (nph != P_DOWN) begin
        noe = m_oe & oe_req;
        if (m_cyc - m_last >= STAG)
          for (int p = 0; p < NP; p++)
            if (!done && oe_req[p] && !m_oe[p]) begin noe[p] = 1; m_last = m_cyc; done = 1; end
      end
    end
    if (nph != P_ACT && nph != P_RET) noe = '0;
    m_oe   = noe;
    m_bias = (nph == P_OFF) ? 1'b0 : (nph == P_DOWN) ? m_bias : 1'b1;
    m_pwr  = (nph == P_OFF || nph == P_BIAS) ? 1'b0 : (nph == P_DOWN) ? m_pwr : 1'b1;
    m_iop  = (nph == P_IO || nph == P_ACT || nph == P_RET);
    m_retc = (nph != P_RET);
    m_rdy  = (nph == P_ACT);
    m_busy = (nph == P_ACT) && |(oe_req & ~noe);
    m_ph   = nph;
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_reset(); else m_edge();

  function automatic logic [NP*PA-1:0] exp_bus();
    logic [6:0] a;
    a = {m_slw, m_drv, m_retc, m_bias, m_iop, m_pwr};
    return {NP{PA'(a)}};
  endfunction

  always @(negedge clk) begin
    chk("oe", 128'(pad_oe), 128'(m_oe));
    chk("attr", 128'(attr_bus), 128'(exp_bus()));
    chk("ready", 128'(ready), 128'(m_rdy));
    chk("busy", 128'(busy), 128'(m_busy));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [PA-1:0] lane0();
    return attr_bus[PA-1:0];
  endfunction

  initial begin
    step(3);
    chk("rst_oe", 128'(pad_oe), 0);
    chk("rst_attr", 128'(lane0()), 128'h0008);
    chk("rst_ready", 128'(ready), 0);
    rst_n = 1; en = 1;
    step(1);  chk("pu_bias", 128'(lane0()), 128'h000C);
    step(15); chk("pu_pre_pwr", 128'(lane0()), 128'h000C);
    step(1);  chk("pu_pwr", 128'(lane0()), 128'h000D);
    step(16); chk("pu_io", 128'(lane0()), 128'h000F);
    step(15); chk("pu_pre_rdy", 128'(ready), 0);
    step(1);  chk("pu_rdy", 128'(ready), 1); chk("pu_oe", 128'(pad_oe), 0);
    oe_req = 8'hFF;
    for (int j = 0; j < 8; j++) begin
      step(j == 0 ? 1 : 2);
      chk("stag_oe", 128'(pad_oe), 128'((1 << (j + 1)) - 1));
      if (j < 7) chk("stag_busy", 128'(busy), 1);
    end
    chk("stag_busy_end", 128'(busy), 0);
    oe_req = 8'h00; step(1); chk("drop_oe", 128'(pad_oe), 0);
    oe_req = 8'h0F; step(1); chk("wd_first", 128'(pad_oe), 128'h01); chk("wd_busy1", 128'(busy), 1);
    oe_req = 8'h01; step(1); chk("wd_busy0", 128'(busy), 0);
    step(4); chk("wd_oe", 128'(pad_oe), 128'h01);
    oe_req = 8'h05; step(2); chk("ret_pre_oe", 128'(pad_oe), 128'h05);
    drv = 2'b10; slw = 1; step(1); chk("drv_sample", 128'(lane0()), 128'h006F);
    ret = 1; step(1); chk("ret_retc", 128'(lane0()), 128'h0067); chk("ret_ready", 128'(ready), 0);
    oe_req = 8'hFF; drv = 2'b01; slw = 0; en = 0;
    step(3); chk("ret_oe", 128'(pad_oe), 128'h05); chk("ret_hold", 128'(lane0()), 128'h0067);
    ret = 0; en = 1; drv = 2'b10; slw = 1;
    step(1); chk("ret_exit", 128'(lane0()), 128'h006F); chk("ret_exit_rdy", 128'(ready), 1);
    step(20); chk("fill_oe", 128'(pad_oe), 128'hFF);
    en = 0;
    step(1);  chk("pd_oe", 128'(pad_oe), 0); chk("pd_io", 128'(lane0()), 128'h006D);
    step(15); chk("pd_hold", 128'(lane0()), 128'h006D);
    step(1);  chk("pd_off", 128'(lane0()), 128'h0068);
    en = 1; step(20);
    chk("ar_pre", 128'(lane0()), 128'h006D);
    #3 rst_n = 0;
    #1 chk("ar_attr", 128'(lane0()), 128'h0008); chk("ar_oe", 128'(pad_oe), 0); chk("ar_rdy", 128'(ready), 0);
    @(negedge clk); rst_n = 1;
    step(1);  chk("ar_bias", 128'(lane0()), 128'h000C);
    step(16); chk("ar_pwr", 128'(lane0()), 128'h000D);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom % 48 == 0) en = ~en;
      if ($urandom % 16 == 0) ret = ~ret;
      if ($urandom % 4 == 0) oe_req = NP'($urandom);
      if ($urandom % 8 == 0) begin drv = 2'($urandom); slw = 1'($urandom); end
      if ($urandom % 700 == 0) begin #2 rst_n = 0; #1 rst_n = 1; end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gf22_pad_bank_seq.md
# gf22_pad_bank_seq

Sequenced controller for a bank of `NPADS` GF22 GPIO pads on one die side. It drives the per-pad attribute buses (BIAS, PWROK, IOPWROK, RETC, DRV, SLW) through a timed power-up/power-down FSM and supports an IO retention mode. It also staggers per-pad output-enable assertions to bound simultaneous switching noise. It sits between the pad-control registers and the `gf22_pad_cell_output` instances of one side.

## Interface
- `NPADS`, 8: pads in the bank, 1..32.
- `PADATTR`, 16: attribute width per pad, at least 7.
- `SIDE`, `core_v_mini_mcu_pkg::TOP`: placement tag, passed through to instantiation only, no functional effect.
- `SETTLE_CYCLES`, 16: cycles spent in each power sequencing step, 1..255.
- `STAGGER_CYCLES`, 2: minimum spacing between two OE assertions, 1..255.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `en_i`  in  1  bank power request. 1 = power up, 0 = power down.
- `ret_i`  in  1  retention request.
- `drv_i`  in  2  drive strength for all pads.
- `slw_i`  in  1  slew control for all pads.
- `oe_req_i`  in  NPADS  requested output enable per pad.
- `pad_oe_o`  out  NPADS  granted output enable per pad.
- `pad_attributes_o`  out  NPADS*PADATTR  per-pad attributes, pad i at `[i*PADATTR +: PADATTR]`:
  - bit 0 PWROK, bit 1 IOPWROK, bit 2 BIAS, bit 3 RETC.
  - bits 5:4 DRV, bit 6 SLW.
  - all higher bits 0.
  - all pads carry identical attributes.
- `ready_o`  out  1  1 only in ACTIVE.
- `busy_o`  out  1  at least one OE assertion pending.

## Operation
- All outputs are registered.
- Reset values:
  - `pad_oe_o`=0, PWROK=IOPWROK=BIAS=0, RETC=1, DRV=0, SLW=0.
  - `ready_o`=0, `busy_o`=0.
  - state OFF, both counters 0.
- States and transitions:
  - OFF: `en_i`=1 moves to BIAS_UP and loads the settle counter with SETTLE_CYCLES-1.
  - BIAS_UP: BIAS=1. When the counter reaches 0, move to PWR_UP and reload.
  - PWR_UP: PWROK=1. When the counter reaches 0, move to IO_UP and reload.
  - IO_UP: IOPWROK=1. When the counter reaches 0, move to ACTIVE.
  - ACTIVE: `ready_o`=1.
    - `ret_i`=1 moves to RET; this has priority over `en_i`=0.
    - otherwise `en_i`=0 moves to DOWN and reloads the counter.
  - RET: RETC=0. `pad_oe_o`, DRV and SLW are frozen and `oe_req_i` is ignored. `en_i` is ignored in RET.
    - `ret_i`=0 moves to ACTIVE with RETC=1 on the next cycle.
  - DOWN: `pad_oe_o`=0 and IOPWROK=0. When the counter reaches 0, move to OFF with PWROK=0 and BIAS=0.
    - `en_i`=1 during DOWN does not abort; the FSM reaches OFF first.
  - `en_i`=0 in BIAS_UP, PWR_UP or IO_UP moves to DOWN immediately and reloads the counter.
- OE staggering, ACTIVE only:
  - Deassertions: every pad with `oe_req_i`=0 drops its `pad_oe_o` on the next cycle, all pads together.
  - Assertions: when the stagger counter is 0, the lowest-index pad with `oe_req_i`=1 and `pad_oe_o`=0 is granted on the next cycle, and the counter loads STAGGER_CYCLES-1.
  - The stagger counter decrements to 0 every cycle in every state.
  - A request withdrawn before its grant is never granted.
- `busy_o` = OR over (`oe_req_i` & ~`pad_oe_o`), registered; forced 0 outside ACTIVE.
- DRV and SLW sample `drv_i` and `slw_i` every cycle in ACTIVE only and hold their values in all other states.
- `pad_oe_o` is 0 in every state except ACTIVE and RET.

## Timing
- `en_i` sampled 1 at edge k in OFF:
  - BIAS=1 after edge k+1.
  - PWROK=1 after edge k+1+S.
  - IOPWROK=1 after edge k+1+2S.
  - `ready_o`=1 after edge k+1+3S, where S = SETTLE_CYCLES.
  - With S=16, `ready_o` rises after edge k+49.
- The first OE grant in ACTIVE comes 1 cycle after the request is seen.
- N simultaneous requests all complete after 1+(N-1)*STAGGER_CYCLES cycles.
- `en_i` sampled 0 in ACTIVE at edge k:
  - `pad_oe_o`=0 and IOPWROK=0 after edge k+1.
  - BIAS=0 and PWROK=0 after edge k+1+S.
- RET entry and exit each take 1 cycle.
- Asynchronous reset mid-sequence forces all reset values immediately, including `pad_oe_o`=0 and RETC=1.

## Test plan
- Power-up with S=16: `en_i` 0→1 at edge 0 -> BIAS at 1, PWROK at 17, IOPWROK at 33, `ready_o` at 49; `pad_oe_o` stays 0 throughout.
- Stagger with NPADS=8, STAGGER=2: `oe_req_i` 0x00→0xFF in ACTIVE -> grants in the order pad0..pad7 on cycles 1,3,5,…,15; `busy_o` falls after the pad7 grant.
- Withdrawal: `oe_req_i`=0x0F with pad0 granted, then `oe_req_i`=0x01 -> pads 1..3 are never granted; `pad_oe_o`=0x01 and `busy_o`=0.
- Retention: `pad_oe_o`=0x05, `ret_i`=1 -> RETC=0 after 1 cycle; `oe_req_i` or `drv_i` changes and `en_i`=0 have no effect; `ret_i`=0 -> RETC=1 and ACTIVE.
- Power-down: `en_i`=0 in ACTIVE with `pad_oe_o`=0xFF -> `pad_oe_o`=0x00 and IOPWROK=0 next cycle; PWROK=0 and BIAS=0 S cycles later; state OFF.
- Async reset asserted in PWR_UP -> all outputs at reset values immediately; release of `rst_ni` with `en_i`=1 restarts the full sequence from BIAS_UP.
